// File: rtl/input_port.sv
// Router input port: circular flit buffer with credit return upstream and
// packet-sequence tracking (head/body/tail/single) on the popped flit.
module input_port #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             credit_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [3:0]       dest_o,
  output logic [2:0]       count_o,
  output logic             overflow_o,
  output logic             proto_err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {IDLE, PKT} state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  state_e           state_q, state_d;
  logic [3:0]       dest_q, dest_d;
  logic             credit_q;
  logic             overflow_q, overflow_d;
  logic             proto_err_q, proto_err_d;

  logic             empty, full, push, pop;
  logic [WIDTH-1:0] head;
  logic [1:0]       head_type;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count_q == 3'd0);
  assign full      = (count_q == 3'(DEPTH));
  assign head      = mem_q[rd_ptr_q];
  assign head_type = head[15:14];
  assign pop       = !empty && ready_i;
  // A full buffer still accepts a flit when a slot frees up on the same edge.
  assign push      = valid_i && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    if (valid_i && full && !pop) overflow_d = 1'b1;
  end

  // Packet FSM advances only on the flit leaving the buffer.
  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    proto_err_d = proto_err_q;
    if (pop) begin
      case (head_type)
        FT_HEAD: begin
          if (state_q == PKT) proto_err_d = 1'b1;
          state_d = PKT;
          dest_d  = head[13:10];
        end
        FT_SINGLE: begin
          if (state_q == PKT) proto_err_d = 1'b1;
          state_d = IDLE;
          dest_d  = head[13:10];
        end
        FT_BODY: begin
          if (state_q == IDLE) proto_err_d = 1'b1;
        end
        default: begin
          if (state_q == IDLE) proto_err_d = 1'b1;
          else                 state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      dest_q      <= '0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      dest_q      <= dest_d;
      credit_q    <= pop;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign valid_o     = !empty;
  assign data_o      = head;
  assign credit_o    = credit_q;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign proto_err_o = proto_err_q;
  // A waiting head/single flit announces its destination before it is popped.
  assign dest_o = (valid_o && state_q == IDLE && head_type[1]) ? head[13:10] : dest_q;

endmodule

// File: tb/tb_input_port.sv
// Directed-vector bench for input_port: reset, latency, overflow, full-buffer
// push/pop, packet sequencing, protocol error and mid-packet reset.
module tb_input_port;
  logic        clk, rst, valid_i, ready_i, credit_o, valid_o, overflow_o, proto_err_o;
  logic [15:0] data_i, data_o;
  logic [3:0]  dest_o;
  logic [2:0]  count_o;
  int checks = 0;
  int errors = 0;
  logic [15:0] fl [5] = '{16'hC000, 16'hC400, 16'hC800, 16'hCC00, 16'hD000};
  logic [15:0] fl2 [5] = '{16'hC400, 16'hC800, 16'hCC00, 16'hD000, 16'hD800};

  input_port #(.DEPTH(5), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .credit_o(credit_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .dest_o(dest_o),
    .count_o(count_o), .overflow_o(overflow_o), .proto_err_o(proto_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = 16'h0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = 16'hFFFF;
    #2;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_o); end
    checks++; if (data_o !== 16'h0) begin errors++; $display("FAIL rst_data got %h exp 0000", data_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count_o); end
    checks++; if (credit_o !== 1'b0) begin errors++; $display("FAIL rst_credit got %b exp 0", credit_o); end
    checks++; if (dest_o !== 4'd0) begin errors++; $display("FAIL rst_dest got %0d exp 0", dest_o); end
    checks++; if ({overflow_o, proto_err_o} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b exp 00", {overflow_o, proto_err_o}); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_first_push;
    do_reset();
    data_i = 16'h8C00; valid_i = 1'b1; ready_i = 1'b0;
    step();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL fp_valid got %b exp 1", valid_o); end
    checks++; if (data_o !== 16'h8C00) begin errors++; $display("FAIL fp_data got %h exp 8c00", data_o); end
    checks++; if (dest_o !== 4'd3) begin errors++; $display("FAIL fp_dest got %0d exp 3", dest_o); end
    checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL fp_count got %0d exp 1", count_o); end
    step();
    checks++; if (credit_o !== 1'b0) begin errors++; $display("FAIL fp_nocredit got %b exp 0", credit_o); end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      data_i = fl[k]; valid_i = 1'b1;
      step();
    end
    data_i = 16'hD400;
    step();
    valid_i = 1'b0;
    checks++; if (count_o !== 3'd5) begin errors++; $display("FAIL ovf_count got %0d exp 5", count_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow_o); end
    checks++; if (credit_o !== 1'b0) begin errors++; $display("FAIL ovf_credit0 got %b exp 0", credit_o); end
    ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (data_o !== fl[k]) begin errors++; $display("FAIL ovf_order%0d got %h exp %h", k, data_o, fl[k]); end
      step();
      checks++; if (credit_o !== 1'b1) begin errors++; $display("FAIL ovf_credit%0d got %b exp 1", k, credit_o); end
      checks++; if (count_o !== 3'(4 - k)) begin errors++; $display("FAIL ovf_drain%0d got %0d exp %0d", k, count_o, 4 - k); end
    end
    step();
    ready_i = 1'b0;
    checks++; if (credit_o !== 1'b0) begin errors++; $display("FAIL ovf_credit_end got %b exp 0", credit_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp 0", valid_o); end
  endtask

  task automatic test_full_push_pop;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      data_i = fl[k]; valid_i = 1'b1;
      step();
    end
    data_i = 16'hD800; ready_i = 1'b1;
    step();
    valid_i = 1'b0; ready_i = 1'b0;
    checks++; if (count_o !== 3'd5) begin errors++; $display("FAIL fpp_count got %0d exp 5", count_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b exp 0", overflow_o); end
    checks++; if (credit_o !== 1'b1) begin errors++; $display("FAIL fpp_credit got %b exp 1", credit_o); end
    step();
    checks++; if (credit_o !== 1'b0) begin errors++; $display("FAIL fpp_credit_once got %b exp 0", credit_o); end
    ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (data_o !== fl2[k]) begin errors++; $display("FAIL fpp_order%0d got %h exp %h", k, data_o, fl2[k]); end
      step();
    end
    ready_i = 1'b0;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL fpp_drained got %0d exp 0", count_o); end
  endtask

  task automatic test_packet;
    do_reset();
    ready_i = 1'b1; valid_i = 1'b1; data_i = 16'h8800;
    step();
    checks++; if (dest_o !== 4'd2) begin errors++; $display("FAIL pkt_dest_head got %0d exp 2", dest_o); end
    data_i = 16'h0005;
    step();
    checks++; if (data_o !== 16'h0005) begin errors++; $display("FAIL pkt_body_data got %h exp 0005", data_o); end
    checks++; if (dest_o !== 4'd2) begin errors++; $display("FAIL pkt_dest_body got %0d exp 2", dest_o); end
    checks++; if (credit_o !== 1'b1) begin errors++; $display("FAIL pkt_credit_head got %b exp 1", credit_o); end
    data_i = 16'h4007;
    step();
    checks++; if (dest_o !== 4'd2) begin errors++; $display("FAIL pkt_dest_tail got %0d exp 2", dest_o); end
    valid_i = 1'b0;
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL pkt_empty got %b exp 0", valid_o); end
    checks++; if (dest_o !== 4'd2) begin errors++; $display("FAIL pkt_dest_after got %0d exp 2", dest_o); end
    checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL pkt_proto got %b exp 0", proto_err_o); end
    ready_i = 1'b0; valid_i = 1'b1; data_i = 16'hC400;
    step();
    valid_i = 1'b0;
    checks++; if (dest_o !== 4'd1) begin errors++; $display("FAIL pkt_idle_lookahead got %0d exp 1", dest_o); end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL pkt_single_proto got %b exp 0", proto_err_o); end
  endtask

  task automatic test_proto_err;
    do_reset();
    data_i = 16'h0001; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL perr_early got %b exp 0", proto_err_o); end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    checks++; if (proto_err_o !== 1'b1) begin errors++; $display("FAIL perr_flag got %b exp 1", proto_err_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL perr_popped got %0d exp 0", count_o); end
    checks++; if (credit_o !== 1'b1) begin errors++; $display("FAIL perr_credit got %b exp 1", credit_o); end
    step();
    checks++; if ({credit_o, proto_err_o} !== 2'b01) begin errors++; $display("FAIL perr_sticky got %b exp 01", {credit_o, proto_err_o}); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    do_reset();
    ready_i = 1'b0; valid_i = 1'b1;
    data_i = 16'h8800; step();
    data_i = 16'h0002; step();
    data_i = 16'h0003; step();
    valid_i = 1'b0;
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL rmid_pre got %0d exp 3", count_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", valid_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", count_o); end
    step(); step();
    rst = 1'b0; ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (credit_o === 1'b1) pulses++;
    end
    ready_i = 1'b0;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rmid_credits got %0d exp 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_overflow();
    test_full_push_pop();
    test_packet();
    test_proto_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_port.md
INPUT_PORT -- requirements
Module: input_port

Interface
REQ-001 Parameter DEPTH, default 5, buffer depth in flits; SHALL equal the upstream output port's initial credit count.
REQ-002 Parameter WIDTH, default 16, flit width in bits; the design SHALL support only 16.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 data_i  input  16  flit from the upstream output port.
REQ-006 valid_i  input  1  flit present on data_i this cycle; driven by upstream send_data.
REQ-007 credit_o  output  1  one-cycle pulse that returns one credit upstream; drives upstream inc_credit_i.
REQ-008 data_o  output  16  flit at the buffer head.
REQ-009 valid_o  output  1  buffer not empty.
REQ-010 ready_i  input  1  downstream crossbar accepts data_o this cycle.
REQ-011 dest_o  output  4  destination port of the current packet.
REQ-012 count_o  output  3  number of flits held, 0..DEPTH.
REQ-013 overflow_o  output  1  sticky flag: a flit arrived while the buffer was full.
REQ-014 proto_err_o  output  1  sticky flag: flit type out of sequence.

Function
REQ-015 Flit type SHALL be data[15:14]: 10 head, 00 body, 01 tail, 11 single. Head and single flits SHALL carry the destination in data[13:10].
REQ-016 The buffer SHALL be a circular buffer of DEPTH entries with read and write pointers that wrap from DEPTH-1 to 0. A dual-ported ready FIFO SHALL NOT be used.
REQ-017 Push SHALL occur on a clock edge where valid_i=1 and (count<DEPTH, or a pop occurs in the same cycle).
REQ-018 A pushed flit SHALL appear on data_o, with valid_o=1, one cycle after the push edge when the buffer was empty. Latency is 1 cycle.
REQ-019 Pop SHALL occur on an edge where valid_o=1 and ready_i=1; data_o SHALL then advance to the next entry.
REQ-020 Simultaneous push and pop SHALL leave the count unchanged; this includes the cases count=DEPTH and count=1.
REQ-021 When valid_i=1, count=DEPTH and no pop occurs, the flit SHALL be dropped, overflow_o SHALL be set, and the count and pointers SHALL be unchanged.
REQ-022 credit_o SHALL pulse high for exactly one cycle, in the cycle after each pop. There SHALL be exactly one pulse per popped flit and none otherwise.
REQ-023 Packet FSM states SHALL be IDLE and PKT, evaluated on the popped flit:
  - IDLE + head pop -> PKT, dest_q <= data[13:10].
  - IDLE + single pop -> IDLE, dest_q <= data[13:10].
  - PKT + body pop -> PKT.
  - PKT + tail pop -> IDLE.
REQ-024 Out-of-sequence pops SHALL set proto_err_o and the flit SHALL still be popped and credited:
  - body or tail popped in IDLE: state stays IDLE.
  - head or single popped in PKT: state goes to PKT or IDLE respectively, and dest_q is reloaded.
REQ-025 dest_o SHALL equal data_o[13:10] when valid_o=1, state=IDLE and the head flit is head or single; otherwise dest_o SHALL equal dest_q.
REQ-026 ready_i while valid_o=0 SHALL have no effect.
REQ-027 count_o SHALL always equal pushes minus pops since reset and SHALL never exceed DEPTH.

Reset
REQ-028 While rst=1, the following SHALL be asynchronously forced:
  - count and both pointers to 0.
  - all buffer entries to 0.
  - state to IDLE, dest_q to 0.
  - valid_o=0, data_o=0, credit_o=0, dest_o=0, count_o=0, overflow_o=0, proto_err_o=0.
REQ-029 Reset asserted mid-packet SHALL discard all buffered flits and SHALL issue no credits for them.
REQ-030 The first push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-031 Push head 0x8C00, ready_i=0 -> next cycle valid_o=1, data_o=0x8C00, dest_o=3, count_o=1.
REQ-032 Push 5 flits with ready_i=0, then a 6th -> count_o=5, overflow_o=1, 6th dropped; then ready_i=1 for 5 cycles -> the 5 original flits pop in order, 5 credit_o pulses each lagging its pop by one cycle, count_o=0.
REQ-033 count_o=5 with valid_i=1 and ready_i=1 in the same cycle -> count_o stays 5, overflow_o stays 0, one credit_o pulse.
REQ-034 Stream head(dest 2), body, tail with ready_i=1 -> dest_o=2 throughout the packet, state returns to IDLE after the tail pop, proto_err_o=0.
REQ-035 Pop body flit 0x0001 in IDLE -> proto_err_o=1, flit popped, one credit_o pulse.
REQ-036 Assert rst with 3 flits buffered -> valid_o=0, count_o=0 immediately; no credit_o pulses after rst deasserts.
